auth_req_receiver: RTL and testbench

// Controller-side endpoint of the host authentication message interface. After Type-C attach it requests a message

---
 rtl/auth_req_receiver_pkg.sv | 59 +++++
 rtl/auth_req_receiver_if.sv | 26 ++
 rtl/auth_req_receiver_hdr_decode.sv | 27 ++
 rtl/auth_req_receiver.sv | 176 +++++++++++++++++
 tb/tb_auth_req_receiver.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/auth_req_receiver_pkg.sv
// Shared definitions for the host authentication request path.
// - MSG_LEN: auth message width (overridable by a global `MSG_LEN define)
// - header/type/error codes, FSM state encoding, header/decode structs
// - build_err_msg(): formats the ERROR reply carried on auth_msg_resp_out
`ifndef MSG_LEN
`define MSG_LEN 2079
`endif

package auth_req_receiver_pkg;

  localparam int MSG_LEN = `MSG_LEN;

  // Protocol version and MessageType codes
  localparam logic [7:0] AUTH_VER        = 8'h01;
  localparam logic [7:0] GET_DIGESTS     = 8'h81;
  localparam logic [7:0] GET_CERTIFICATE = 8'h82;
  localparam logic [7:0] CHALLENGE       = 8'h83;
  localparam logic [7:0] T_ERROR         = 8'h7F;

  // Error codes reported on err_code
  localparam logic [7:0] ERR_INVALID_REQ = 8'h01;
  localparam logic [7:0] ERR_UNSUP_PROTO = 8'h02;
  localparam logic [7:0] ERR_TIMEOUT     = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT_MSG = 3'd2,
    S_DECODE   = 3'd3,
    S_SERVE    = 3'd4,
    S_ERR      = 3'd5
  } state_e;

  // 4-byte header at the top of every message
  typedef struct packed {
    logic [7:0] ver;
    logic [7:0] mtype;
    logic [7:0] param1;
    logic [7:0] param2;
  } auth_hdr_t;

  // Decoder result: ok=1 means a supported request; otherwise err_code says why
  typedef struct packed {
    logic       ok;
    logic [7:0] err_code;
    logic [7:0] mtype;
    logic [7:0] param1;
    logic [7:0] param2;
  } hdr_dec_t;

  // ERROR reply: header {ver, ERROR, code, 0}, body all zeros
  function automatic logic [MSG_LEN-1:0] build_err_msg(input logic [7:0] code);
    logic [MSG_LEN-1:0] m;
    m = '0;
    m[MSG_LEN-1 -: 32] = {AUTH_VER, T_ERROR, code, 8'h00};
    return m;
  endfunction

endpackage

// File: rtl/auth_req_receiver_if.sv
// Host message bus between the host and the controller-side receiver.
// - resp_req_in       host -> ctrl  handshake, idles 1, 0 = acknowledge
// - Ack_out_resp      host -> ctrl  message-valid qualifier
// - auth_msg_resp_in  host -> ctrl  auth request message
// - resp_req_out      ctrl -> host  request for a message
// - auth_msg_resp_out ctrl -> host  reply (ERROR) message
// master = host side, slave = controller side.
interface auth_req_receiver_if #(
  parameter int MSG_LEN = auth_req_receiver_pkg::MSG_LEN
);
  logic               resp_req_in;
  logic               Ack_out_resp;
  logic [MSG_LEN-1:0] auth_msg_resp_in;
  logic               resp_req_out;
  logic [MSG_LEN-1:0] auth_msg_resp_out;

  modport master (
    output resp_req_in, Ack_out_resp, auth_msg_resp_in,
    input  resp_req_out, auth_msg_resp_out
  );

  modport slave (
    input  resp_req_in, Ack_out_resp, auth_msg_resp_in,
    output resp_req_out, auth_msg_resp_out
  );
endinterface

// File: rtl/auth_req_receiver_hdr_decode.sv
// Combinational auth header decoder (also used by the responder).
// - hdr_i : 4-byte header {ver, type, param1, param2}
// - dec_o : ok flag, error code when not ok, and the split fields
// A bad version takes precedence over a bad type.
module auth_req_receiver_hdr_decode
  import auth_req_receiver_pkg::*;
(
  input  auth_hdr_t hdr_i,
  output hdr_dec_t  dec_o
);

  always_comb begin
    dec_o          = '0;
    dec_o.mtype    = hdr_i.mtype;
    dec_o.param1   = hdr_i.param1;
    dec_o.param2   = hdr_i.param2;
    if (hdr_i.ver != AUTH_VER) begin
      dec_o.err_code = ERR_UNSUP_PROTO;
    end else if (hdr_i.mtype == GET_DIGESTS || hdr_i.mtype == GET_CERTIFICATE ||
                 hdr_i.mtype == CHALLENGE) begin
      dec_o.ok = 1'b1;
    end else begin
      dec_o.err_code = ERR_INVALID_REQ;
    end
  end

endmodule

// File: rtl/auth_req_receiver.sv
// Controller-side endpoint of the host authentication message interface.
// After attach it requests a message from the host, captures it, decodes the
// header and either hands the request to the responder (req_valid + fields)
// or produces an ERROR reply (err_valid + auth_msg_resp_out).
// Ports:
// - clk, reset       clock, async active-low reset
// - attached         CC attach level
// - rsp_done         responder finished the current request (pulse)
// - host             host message bus (slave side)
// - req_valid        1-cycle pulse, req_type/req_param1/req_param2 valid
// - err_valid        1-cycle pulse, err_code valid (ERROR reply or timeout)
// - busy             FSM not in IDLE
module auth_req_receiver
  import auth_req_receiver_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                attached,
  input  logic                rsp_done,
  auth_req_receiver_if.slave  host,
  output logic                req_valid,
  output logic [7:0]          req_type,
  output logic [7:0]          req_param1,
  output logic [7:0]          req_param2,
  output logic                err_valid,
  output logic [7:0]          err_code,
  output logic                busy
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_e             state_q;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic               timeout_hit;
  logic [MSG_LEN-1:0] msg_q;
  logic [MSG_LEN-1:0] resp_msg_q;
  logic               resp_req_q;
  logic               req_pend_q;
  logic               req_valid_q;
  logic [7:0]         req_type_q, req_p1_q, req_p2_q;
  logic               err_valid_q;
  logic [7:0]         err_code_q;

  logic               cap;
  auth_hdr_t          hdr;
  hdr_dec_t           dec;
  logic               unused_body;

  // The message body is kept for the responder; only the header is decoded here.
  assign hdr         = auth_hdr_t'(msg_q[MSG_LEN-1 -: 32]);
  assign unused_body = ^msg_q[MSG_LEN-33:0];

  auth_req_receiver_hdr_decode u_dec (
    .hdr_i (hdr),
    .dec_o (dec)
  );

  assign cap = !host.resp_req_in && host.Ack_out_resp;

  // Timeout counter: runs only in WAIT_MSG, starts from 0 on entry, so the
  // timeout fires on the TIMEOUT_CYC-th edge spent waiting.
  always_comb begin
    cnt_inc     = cnt_q + CW'(1);
    timeout_hit = (cnt_inc == CW'(TIMEOUT_CYC));
    cnt_d       = (state_q == S_WAIT_MSG) ? cnt_inc : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      msg_q       <= '0;
      resp_msg_q  <= '0;
      resp_req_q  <= 1'b0;
      req_pend_q  <= 1'b0;
      req_valid_q <= 1'b0;
      req_type_q  <= '0;
      req_p1_q    <= '0;
      req_p2_q    <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      // req_valid trails the field load by one cycle, matching the ERR path
      // so both pulses land two edges after capture.
      req_valid_q <= req_pend_q;
      req_pend_q  <= 1'b0;
      err_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (attached) begin
            state_q    <= S_REQ;
            resp_req_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (!attached) begin
            state_q    <= S_IDLE;
            resp_req_q <= 1'b0;
          end else if (!host.resp_req_in) begin
            state_q <= S_WAIT_MSG;
          end
        end
        S_WAIT_MSG: begin
          // Capture is checked before timeout so it wins a same-cycle tie.
          if (!attached) begin
            state_q    <= S_IDLE;
            resp_req_q <= 1'b0;
          end else if (cap) begin
            msg_q      <= host.auth_msg_resp_in;
            resp_req_q <= 1'b0;
            state_q    <= S_DECODE;
          end else if (timeout_hit) begin
            err_valid_q <= 1'b1;
            err_code_q  <= ERR_TIMEOUT;
            resp_req_q  <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        S_DECODE: begin
          if (dec.ok) begin
            req_type_q <= dec.mtype;
            req_p1_q   <= dec.param1;
            req_p2_q   <= dec.param2;
            req_pend_q <= 1'b1;
            state_q    <= S_SERVE;
          end else begin
            err_code_q <= dec.err_code;
            state_q    <= S_ERR;
          end
        end
        S_SERVE: begin
          // Detach here does not abort; the request completes on rsp_done.
          if (rsp_done) begin
            if (attached) begin
              state_q    <= S_REQ;
              resp_req_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_ERR: begin
          resp_msg_q  <= build_err_msg(err_code_q);
          err_valid_q <= 1'b1;
          if (attached) begin
            state_q    <= S_REQ;
            resp_req_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          resp_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign host.resp_req_out      = resp_req_q;
  assign host.auth_msg_resp_out = resp_msg_q;
  assign req_valid              = req_valid_q;
  assign req_type               = req_type_q;
  assign req_param1             = req_p1_q;
  assign req_param2             = req_p2_q;
  assign err_valid              = err_valid_q;
  assign err_code               = err_code_q;
  assign busy                   = (state_q != S_IDLE);

endmodule

// File: tb/tb_auth_req_receiver.sv
// Directed bench for auth_req_receiver: header vector table plus hand-written
// sequences for timeout, capture/timeout tie, detach and reset aborts.
module tb_auth_req_receiver;
  import auth_req_receiver_pkg::*;

  localparam int ML = MSG_LEN;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       attached = 1'b0;
  logic       rsp_done = 1'b0;
  logic       req_valid, err_valid, busy;
  logic [7:0] req_type, req_param1, req_param2, err_code;

  auth_req_receiver_if #(.MSG_LEN(ML)) bus ();

  auth_req_receiver #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .attached   (attached),
    .rsp_done   (rsp_done),
    .host       (bus),
    .req_valid  (req_valid),
    .req_type   (req_type),
    .req_param1 (req_param1),
    .req_param2 (req_param2),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hdr;
    logic        ok;
    logic [7:0]  typ;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic [7:0]  code;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  last_type = 8'h00;
  logic [31:0] last_err_hdr = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ML-1:0] make_msg(input logic [31:0] h);
    logic [ML-1:0] m;
    m = '0;
    for (int i = 0; i < ML - 32; i++) m[i] = 1'($urandom_range(1, 0));
    m[ML-1 -: 32] = h;
    return m;
  endfunction

  // One full request starting in REQ and ending back in REQ.
  task automatic run_vec(input int idx, input vec_t v);
    chk($sformatf("v%0d_pre_req", idx), 64'(bus.resp_req_out), 64'd1);
    bus.resp_req_in      = 1'b0;
    bus.Ack_out_resp     = 1'b1;
    bus.auth_msg_resp_in = make_msg(v.hdr);
    step();                                   // REQ -> WAIT_MSG
    step();                                   // capture
    chk($sformatf("v%0d_req_drop", idx), 64'(bus.resp_req_out), 64'd0);
    bus.resp_req_in      = 1'b1;
    bus.Ack_out_resp     = 1'b0;
    bus.auth_msg_resp_in = '0;
    step();                                   // DECODE
    chk($sformatf("v%0d_no_early_pulse", idx), 64'({req_valid, err_valid}), 64'd0);
    step();                                   // two edges after capture
    if (v.ok) begin
      chk($sformatf("v%0d_req_valid", idx), 64'(req_valid), 64'd1);
      chk($sformatf("v%0d_req_fields", idx), 64'({req_type, req_param1, req_param2}),
          64'({v.typ, v.p1, v.p2}));
      chk($sformatf("v%0d_no_err", idx), 64'(err_valid), 64'd0);
      rsp_done = 1'b1;
      step();
      rsp_done = 1'b0;
      chk($sformatf("v%0d_pulse_end", idx), 64'(req_valid), 64'd0);
      chk($sformatf("v%0d_back_req", idx), 64'({busy, bus.resp_req_out}), 64'd3);
      last_type = v.typ;
    end else begin
      chk($sformatf("v%0d_err_valid", idx), 64'(err_valid), 64'd1);
      chk($sformatf("v%0d_err_code", idx), 64'(err_code), 64'(v.code));
      chk($sformatf("v%0d_err_hdr", idx), 64'(bus.auth_msg_resp_out[ML-1 -: 32]),
          64'({8'h01, 8'h7F, v.code, 8'h00}));
      chk($sformatf("v%0d_err_body", idx), 64'(|bus.auth_msg_resp_out[ML-33:0]), 64'd0);
      chk($sformatf("v%0d_no_req", idx), 64'(req_valid), 64'd0);
      chk($sformatf("v%0d_type_held", idx), 64'(req_type), 64'(last_type));
      chk($sformatf("v%0d_back_req", idx), 64'(bus.resp_req_out), 64'd1);
      last_err_hdr = {8'h01, 8'h7F, v.code, 8'h00};
      step();
      chk($sformatf("v%0d_err_end", idx), 64'(err_valid), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = '{32'h01_81_00_00, 1'b1, 8'h81, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{32'h02_81_00_00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h02};
    vecs[2] = '{32'h01_05_00_00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01};
    vecs[3] = '{32'h01_83_01_00, 1'b1, 8'h83, 8'h01, 8'h00, 8'h00};
    vecs[4] = '{32'h01_82_03_04, 1'b1, 8'h82, 8'h03, 8'h04, 8'h00};
    vecs[5] = '{32'h00_7F_00_00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h02};
    vecs[6] = '{32'h01_80_00_00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01};
    vecs[7] = '{32'h02_05_00_00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h02};
    vecs[8] = '{32'h01_84_00_00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01};

    bus.resp_req_in      = 1'b1;
    bus.Ack_out_resp     = 1'b0;
    bus.auth_msg_resp_in = '0;

    // Reset held low for 4 cycles
    #1 reset = 1'b0;
    repeat (4) step();
    chk("rst_outputs", 64'({req_valid, err_valid, busy, bus.resp_req_out}), 64'd0);
    chk("rst_fields", 64'({req_type, req_param1, req_param2, err_code}), 64'd0);
    chk("rst_resp_msg", 64'(|bus.auth_msg_resp_out), 64'd0);
    reset = 1'b1;
    step();
    step();
    chk("idle_unattached", 64'({busy, bus.resp_req_out}), 64'd0);

    // Attach: resp_req_out rises on the next edge
    attached = 1'b1;
    step();
    chk("attach_req", 64'({busy, bus.resp_req_out}), 64'd3);
    step();
    step();

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Capture and timeout on the same edge: capture wins
    bus.resp_req_in  = 1'b0;
    bus.Ack_out_resp = 1'b0;
    step();                                   // enter WAIT_MSG
    repeat (15) step();
    chk("tie_no_early_to", 64'(err_valid), 64'd0);
    bus.Ack_out_resp     = 1'b1;
    bus.auth_msg_resp_in = make_msg(32'h01_82_00_00);
    step();
    chk("tie_no_timeout", 64'({err_valid, bus.resp_req_out}), 64'd0);
    bus.resp_req_in  = 1'b1;
    bus.Ack_out_resp = 1'b0;
    step();
    step();
    chk("tie_req_valid", 64'({req_valid, req_type}), 64'({1'b1, 8'h82}));
    rsp_done = 1'b1;
    step();
    rsp_done = 1'b0;
    chk("tie_back_req", 64'(bus.resp_req_out), 64'd1);

    // Host never acks: timeout exactly TO edges after WAIT_MSG entry
    bus.resp_req_in = 1'b0;
    step();                                   // enter WAIT_MSG
    repeat (15) step();
    chk("to_not_yet", 64'({err_valid, bus.resp_req_out}), 64'b01);
    step();
    chk("to_err_valid", 64'(err_valid), 64'd1);
    chk("to_err_code", 64'(err_code), 64'hFF);
    chk("to_idle", 64'({busy, bus.resp_req_out}), 64'd0);
    chk("to_resp_held", 64'(bus.auth_msg_resp_out[ML-1 -: 32]), 64'(last_err_hdr));
    bus.resp_req_in = 1'b1;
    step();
    chk("to_rereq", 64'({err_valid, bus.resp_req_out}), 64'b01);

    // Detach in REQ: abort, no pulses
    attached = 1'b0;
    step();
    chk("detach_req_idle", 64'({busy, bus.resp_req_out}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("detach_quiet%0d", i), 64'({req_valid, err_valid, busy}), 64'd0);
    end

    // Reset in WAIT_MSG
    attached = 1'b1;
    step();
    bus.resp_req_in = 1'b0;
    step();                                   // enter WAIT_MSG
    step();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    attached = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_async", 64'({busy, bus.resp_req_out}), 64'd0);
    chk("rst_clears_resp", 64'(|bus.auth_msg_resp_out), 64'd0);
    step();
    reset = 1'b1;
    bus.resp_req_in = 1'b1;
    step();
    chk("rst_quiet", 64'({req_valid, err_valid, busy}), 64'd0);

    // Detach during SERVE: request still completes on rsp_done
    attached = 1'b1;
    step();
    bus.resp_req_in      = 1'b0;
    bus.Ack_out_resp     = 1'b1;
    bus.auth_msg_resp_in = make_msg(32'h01_81_05_06);
    step();
    step();
    bus.resp_req_in  = 1'b1;
    bus.Ack_out_resp = 1'b0;
    step();                                   // now in SERVE
    attached = 1'b0;
    step();
    chk("serve_hold_busy", 64'({busy, req_valid}), 64'b11);
    chk("serve_fields", 64'({req_type, req_param1, req_param2}), 64'h81_05_06);
    step();
    chk("serve_still_busy", 64'(busy), 64'd1);
    rsp_done = 1'b1;
    step();
    rsp_done = 1'b0;
    chk("serve_exit_idle", 64'({busy, bus.resp_req_out}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
